// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, stream
// constants and the instruction memory geometry.
// Optional build macro: LOADER_CHECKSUM_EN (adds the CHK state).
package loader_pkg;

    // Geometry of the instruction RAM this loader writes into.
    localparam int LDR_ADDR_W = 12;
    localparam int LDR_DATA_W = 17;
    localparam int LDR_DEPTH  = 2048;

    // Start-of-image marker.
    localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

    // Each instruction word travels as this many bytes, LSB first.
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_LO = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_B0     = 4'd3,
        ST_B1     = 4'd4,
        ST_B2     = 4'd5,
        ST_DONE   = 4'd6,
        ST_ERR    = 4'd7
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHK    = 4'd8
`endif
    } loader_state_e;

    // The top byte of a word only carries bit 16; anything in bits 7:1 is
    // a corrupted stream.
    function automatic logic pad_bits_set(input logic [7:0] top_byte);
        return |top_byte[7:1];
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Collects the low bytes of an instruction word. The final (top) byte is
// not stored: the word and the padding flag are formed from the two held
// bytes plus the live byte, so the loader can decide and write on the same
// strobe that delivers the last byte.
module instr_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [16:0] word_o,
    output logic        pad_err_o
);

    localparam int HELD_W = (BYTES_PER_WORD - 1) * 8;

    logic [HELD_W-1:0] held_q;
    logic [HELD_W-1:0] held_d;

    // Shift a new byte in from the top so the first byte ends up lowest.
    always_comb begin
        held_d = held_q;
        if (load) begin
            held_d = {byte_in, held_q[HELD_W-1:8]};
        end else begin
            held_d = held_q;
        end
    end

    // Byte holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            held_q <= held_d;
        end
    end

    assign word_o    = {byte_in[0], held_q};
    assign pad_err_o = pad_bits_set(byte_in);

endmodule

// File: rtl/instr_loader.sv
// Instruction RAM writer: parses SYNC / length / word stream from the UART
// byte strobe, writes words into the instruction RAM and holds the core in
// reset until a complete image is in place.
// Optional build macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module instr_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = LDR_ADDR_W,
    parameter int         DATA_W    = LDR_DATA_W,
    parameter int         DEPTH     = LDR_DEPTH,
    parameter logic [7:0] SYNC_BYTE = LDR_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              core_hold
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    loader_state_e     state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              core_hold_q, core_hold_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic              asm_load_s;
    logic [16:0]       word_s;
    logic              pad_err_s;
    logic [15:0]       n_s;

    assign n_s = {rx_data, len_lo_q};

    instr_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .load      (asm_load_s),
        .byte_in   (rx_data),
        .word_o    (word_s),
        .pad_err_o (pad_err_s)
    );

    // Next-state and next-output logic; only strobed bytes move the FSM.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        core_hold_d = core_hold_q;
        len_lo_d    = len_lo_q;
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        asm_load_s  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        if (rx_valid) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d     = ST_LEN_LO;
                        busy_d      = 1'b1;
                        core_hold_d = 1'b1;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        idx_d       = '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_d       = 8'h00;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_d = rx_data;
                    state_d  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (n_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d     = ST_CHK;
`else
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
`endif
                    end else if (n_s > DEPTH_W) begin
                        state_d     = ST_ERR;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                        core_hold_d = 1'b1;
                    end else begin
                        state_d    = ST_B0;
                        idx_d      = '0;
                        last_idx_d = n_s[ADDR_W-1:0] - ADDR_W'(1);
                    end
                end
                ST_B0: begin
                    asm_load_s = 1'b1;
                    state_d    = ST_B1;
                end
                ST_B1: begin
                    asm_load_s = 1'b1;
                    state_d    = ST_B2;
                end
                ST_B2: begin
                    if (pad_err_s) begin
                        state_d     = ST_ERR;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                        core_hold_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = word_s;
                        if (idx_q == last_idx_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d     = ST_CHK;
`else
                            state_d     = ST_DONE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            core_hold_d = 1'b0;
`endif
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = ST_B0;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_data == xor_q) begin
                        state_d     = ST_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d     = ST_ERR;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                        core_hold_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    core_hold_d = 1'b1;
                end
            endcase
`ifdef LOADER_CHECKSUM_EN
            // Every byte after SYNC up to the checksum itself is folded in.
            if (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
                state_q == ST_B0 || state_q == ST_B1 || state_q == ST_B2) begin
                xor_d = xor_q ^ rx_data;
            end else begin
                xor_d = xor_d;
            end
`endif
        end else begin
            state_d = state_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_hold_q <= 1'b1;
            len_lo_q    <= 8'h00;
            idx_q       <= '0;
            last_idx_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_hold_q <= core_hold_d;
            len_lo_q    <= len_lo_d;
            idx_q       <= idx_d;
            last_idx_q  <= last_idx_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign core_hold = core_hold_q;

endmodule
